// File: rtl/mat_mul_seq.sv
// Loads A (rows) and B (columns), issues all N*N row/column pairs to the dot-product engine, then streams C = A*B by row.
// Latency: last input beat to first out_valid is N*N + engine latency + 1; only out_ready can stall, and only while draining.
module mat_mul_seq #(
  parameter int DW = 32,
  parameter int N  = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [N-1:0][DW-1:0]  in_data,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic [N-1:0][DW-1:0]  dp_row_vec,
  output logic [N-1:0][DW-1:0]  dp_col_vec,
  output logic                  dp_valid,
  input  logic [DW-1:0]         dp_dout,
  input  logic                  dp_dout_valid,
  output logic [N-1:0][DW-1:0]  out_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  out_last,
  output logic                  busy
);

  localparam int NN = N * N;
  localparam int CW = $clog2(NN) + 1;
  localparam int IW = $clog2(N);

  typedef enum logic [2:0] {IDLE, LOAD, ISSUE, WAIT, DRAIN} state_t;

  state_t state, state_nxt;

  logic [N-1:0][DW-1:0] a_mem [N];
  logic [N-1:0][DW-1:0] b_mem [N];
  logic [N-1:0][DW-1:0] c_mem [N];

  logic [CW-1:0] ld_cnt;
  logic [CW-1:0] iss_cnt;
  logic [CW-1:0] res_cnt;
  logic [CW-1:0] row_cnt;
  logic [CW-1:0] iss_nxt;

  logic ld_take, ld_last, iss_last, res_take, res_last, drain_take, drain_last;

  // N is a power of two, so the low/high IW bits of a counter give column/row indices.
  assign iss_nxt    = iss_cnt + CW'(1);
  assign ld_take    = (state == LOAD) && in_valid;
  assign ld_last    = ld_take && (ld_cnt == CW'(2*N-1));
  assign iss_last   = (state == ISSUE) && (iss_cnt == CW'(NN-1));
  assign res_take   = ((state == ISSUE) || (state == WAIT)) && dp_dout_valid;
  assign res_last   = res_take && (res_cnt == CW'(NN-1));
  assign drain_take = (state == DRAIN) && out_ready;
  assign drain_last = drain_take && (row_cnt == CW'(N-1));

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    state_nxt = LOAD;
      LOAD:    if (ld_last) state_nxt = ISSUE;
      ISSUE:   if (iss_last) state_nxt = WAIT;
      WAIT:    if (res_last && (state == WAIT)) state_nxt = DRAIN;
      DRAIN:   if (drain_last) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state == LOAD);
    busy      = (state != IDLE);
    out_valid = (state == DRAIN);
    out_last  = out_valid && (row_cnt == CW'(N-1));
    out_data  = out_valid ? c_mem[row_cnt[IW-1:0]] : '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      ld_cnt     <= '0;
      iss_cnt    <= '0;
      res_cnt    <= '0;
      row_cnt    <= '0;
      dp_valid   <= 1'b0;
      dp_row_vec <= '0;
      dp_col_vec <= '0;
    end else begin
      state <= state_nxt;
      if (ld_take) ld_cnt <= ld_last ? '0 : ld_cnt + CW'(1);
      // The first pair is staged while the final B column is still being written; it only needs A[0] and B[0].
      if (ld_last) begin
        dp_valid   <= 1'b1;
        dp_row_vec <= a_mem[0];
        dp_col_vec <= b_mem[0];
        iss_cnt    <= '0;
        res_cnt    <= '0;
      end
      if (state == ISSUE) begin
        if (iss_last) begin
          dp_valid <= 1'b0;
          iss_cnt  <= '0;
        end else begin
          iss_cnt    <= iss_nxt;
          dp_row_vec <= a_mem[iss_nxt[2*IW-1:IW]];
          dp_col_vec <= b_mem[iss_nxt[IW-1:0]];
        end
      end
      if (res_take) res_cnt <= res_last ? '0 : res_cnt + CW'(1);
      if (drain_take) row_cnt <= drain_last ? '0 : row_cnt + CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && ld_take) begin
      if (ld_cnt < CW'(N)) a_mem[ld_cnt[IW-1:0]] <= in_data;
      else                 b_mem[ld_cnt[IW-1:0]] <= in_data;
    end
    if (!rst && res_take) c_mem[res_cnt[2*IW-1:IW]][res_cnt[IW-1:0]] <= dp_dout;
  end

endmodule
